// File: rtl/rast_pkg.sv
// Shared encodings for the test-pattern rasterizer: pattern modes and FSM states.
package rast_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rast_xy_counter.sv
// Raster-order x/y counter advanced only on accepted pixels; exposes next
// coordinates so colour can be registered in step with them.
module rast_xy_counter #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int X_W   = 10,
  parameter int Y_W   = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear_i,
  input  logic           advance_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic [X_W-1:0] x_next_o,
  output logic [Y_W-1:0] y_next_o,
  output logic           last_o
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (advance_i) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign x_next_o = x_d;
  assign y_next_o = y_d;
  assign last_o   = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/test_pattern_rasterizer.sv
// Frame-paced test-pattern source: emits one raster-order frame per buffer swap
// with solid / bars / checker / gradient colouring over a valid/ready handshake.
module test_pattern_rasterizer
  import rast_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int COLOR_W    = 3,
  parameter int CHK_LOG    = 5,
  parameter int GRAD_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dont_change,
  input  logic [1:0]         mode_sel,
  input  logic               mode_auto,
  input  logic               next_frame_switch,
  input  logic               read_rast_pixel_rdy,
  output logic               rast_pixel_rdy,
  output logic [COLOR_W-1:0] rast_color_input,
  output logic [X_W-1:0]     rast_width,
  output logic [Y_W-1:0]     rast_height,
  output logic               rast_done,
  output logic [7:0]         frame_count,
  output logic [1:0]         cur_mode
);

  localparam int BAR_W_RAW = H_RES >> COLOR_W;
  localparam int BAR_W     = (BAR_W_RAW < 1) ? 1 : BAR_W_RAW;
  localparam logic [X_W-1:0]     BAR_LAST  = X_W'(BAR_W - 1);
  localparam logic [COLOR_W-1:0] COLOR_MAX = '1;

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [COLOR_W-1:0]   solid_q, solid_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic [COLOR_W-1:0]   bar_idx_q, bar_idx_d;
  logic [X_W-1:0]       bar_pos_q, bar_pos_d;
  logic [7:0]           frame_count_q, frame_count_d;

  logic                 frame_start, xfer, last_pix, frame_end;
  logic [X_W-1:0]       x_next;
  logic [Y_W-1:0]       y_next;
  logic [X_W:0]         grad_sum;
  logic                 chk_bit;
  logic [COLOR_W-1:0]   chk_color, pattern;

  // A swap pulse arriving mid-frame is deliberately dropped, not queued.
  assign frame_start = next_frame_switch && (state_q != DRAW);
  assign xfer        = rast_pixel_rdy && read_rast_pixel_rdy;
  assign frame_end   = xfer && last_pix;

  rast_xy_counter #(
    .H_RES(H_RES),
    .V_RES(V_RES),
    .X_W  (X_W),
    .Y_W  (Y_W)
  ) u_xy (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (frame_start),
    .advance_i(xfer),
    .x_o      (rast_width),
    .y_o      (rast_height),
    .x_next_o (x_next),
    .y_next_o (y_next),
    .last_o   (last_pix)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (next_frame_switch) state_d = DRAW;
      DRAW:    if (frame_end) state_d = DONE;
      DONE:    if (next_frame_switch) state_d = DRAW;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rast_pixel_rdy = (state_q == DRAW);
    rast_done      = (state_q == DONE);
  end

  always_comb begin
    mode_d  = mode_q;
    solid_d = solid_q;
    if (frame_start && !dont_change) begin
      mode_d  = mode_auto ? mode_e'(mode_q + 2'd1) : mode_e'(mode_sel);
      solid_d = solid_q + COLOR_W'(1);
    end
  end

  // Bar index tracks x incrementally so no divider by BAR_W is needed.
  always_comb begin
    bar_idx_d = bar_idx_q;
    bar_pos_d = bar_pos_q;
    if (frame_start || (xfer && x_next == '0)) begin
      bar_idx_d = '0;
      bar_pos_d = '0;
    end else if (xfer) begin
      if (bar_pos_q == BAR_LAST) begin
        bar_pos_d = '0;
        bar_idx_d = (bar_idx_q == COLOR_MAX) ? bar_idx_q : bar_idx_q + COLOR_W'(1);
      end else begin
        bar_pos_d = bar_pos_q + X_W'(1);
      end
    end
  end

  assign chk_bit  = x_next[CHK_LOG] ^ y_next[CHK_LOG];
  assign grad_sum = {1'b0, x_next} + (X_W+1)'(y_next);

  genvar gi;
  for (gi = 0; gi < COLOR_W; gi++) begin : g_chk
    assign chk_color[gi] = chk_bit;
  end

  always_comb begin
    pattern = solid_d;
    unique case (mode_d)
      MODE_SOLID: pattern = solid_d;
      MODE_BARS:  pattern = bar_idx_d;
      MODE_CHECK: pattern = chk_color;
      MODE_GRAD:  pattern = COLOR_W'(grad_sum >> GRAD_SHIFT);
      default:    pattern = solid_d;
    endcase
  end

  always_comb begin
    color_d       = color_q;
    frame_count_d = frame_count_q;
    if (frame_start || xfer) color_d = pattern;
    if (frame_end) frame_count_d = frame_count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mode_q        <= MODE_SOLID;
      solid_q       <= '0;
      color_q       <= '0;
      bar_idx_q     <= '0;
      bar_pos_q     <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      solid_q       <= solid_d;
      color_q       <= color_d;
      bar_idx_q     <= bar_idx_d;
      bar_pos_q     <= bar_pos_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign rast_color_input = color_q;
  assign frame_count      = frame_count_q;
  assign cur_mode         = mode_q;

endmodule

// File: tb/tb_test_pattern_rasterizer.sv
// Randomised frame-level bench for test_pattern_rasterizer at an 8x4 resolution.
module tb_test_pattern_rasterizer;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int XW = 3;
  localparam int YW = 2;
  localparam int CW = 3;
  localparam int CL = 1;
  localparam int GS = 0;
  localparam int BW = ((H >> CW) < 1) ? 1 : (H >> CW);
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          dont_change;
  logic [1:0]    mode_sel;
  logic          mode_auto;
  logic          next_frame_switch;
  logic          read_rast_pixel_rdy;
  logic          rast_pixel_rdy;
  logic [CW-1:0] rast_color_input;
  logic [XW-1:0] rast_width;
  logic [YW-1:0] rast_height;
  logic          rast_done;
  logic [7:0]    frame_count;
  logic [1:0]    cur_mode;

  test_pattern_rasterizer #(
    .H_RES(H), .V_RES(V), .X_W(XW), .Y_W(YW),
    .COLOR_W(CW), .CHK_LOG(CL), .GRAD_SHIFT(GS)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .dont_change        (dont_change),
    .mode_sel           (mode_sel),
    .mode_auto          (mode_auto),
    .next_frame_switch  (next_frame_switch),
    .read_rast_pixel_rdy(read_rast_pixel_rdy),
    .rast_pixel_rdy     (rast_pixel_rdy),
    .rast_color_input   (rast_color_input),
    .rast_width         (rast_width),
    .rast_height        (rast_height),
    .rast_done          (rast_done),
    .frame_count        (frame_count),
    .cur_mode           (cur_mode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_mode = 0;
  int m_solid = 0;
  int m_fc = 0;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference colour derived from the pattern definitions, not the datapath.
  function automatic int exp_color(input int x, input int y);
    int b;
    case (m_mode)
      0: return m_solid;
      1: begin
        b = x / BW;
        return (b > CMAX) ? CMAX : b;
      end
      2: return (((x >> CL) ^ (y >> CL)) & 1) ? CMAX : 0;
      default: return ((x + y) >> GS) & CMAX;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"},  rast_pixel_rdy, 0);
    check({tag, "_done"}, rast_done, 0);
    check({tag, "_fc"},   frame_count, 0);
    check({tag, "_mode"}, cur_mode, 0);
    check({tag, "_col"},  rast_color_input, 0);
    check({tag, "_x"},    rast_width, 0);
    check({tag, "_y"},    rast_height, 0);
  endtask

  // style: 0 ready always high, 1 toggled, 2 random.
  task automatic run_frame(input logic [1:0] sel, input bit aut, input bit dc,
                           input int style, input int switch_at, input int rst_at);
    int  p, cyc, x, y, col;
    bit  r, v, sw_done;
    @(negedge clk);
    mode_sel = sel; mode_auto = aut; dont_change = dc; next_frame_switch = 1'b1;
    if (!dc) begin
      m_mode  = aut ? (m_mode + 1) % 4 : int'(sel);
      m_solid = (m_solid + 1) % (CMAX + 1);
    end
    @(negedge clk);
    next_frame_switch = 1'b0;
    p = 0; cyc = 0; sw_done = 0;
    while (p < H * V && cyc < 400) begin
      x = p % H; y = p / H; col = exp_color(x, y);
      v = rast_pixel_rdy;
      check("draw_rdy", rast_pixel_rdy, 1);
      check("draw_done", rast_done, 0);
      check("pix_x", rast_width, x);
      check("pix_y", rast_height, y);
      check("pix_col", rast_color_input, col);
      check("pix_mode", cur_mode, m_mode);
      if (p == rst_at) begin
        #2 rst = 1'b1;
        read_rast_pixel_rdy = 1'b0;
        #1 check_all_zero("abort");
        m_fc = 0; m_mode = 0; m_solid = 0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      case (style)
        0: r = 1'b1;
        1: r = (cyc % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      read_rast_pixel_rdy = r;
      next_frame_switch = (p == switch_at) && !sw_done;
      if (p == switch_at) sw_done = 1;
      mode_sel = 2'($urandom); mode_auto = 1'($urandom); dont_change = 1'($urandom);
      @(negedge clk);
      next_frame_switch = 1'b0;
      if (r && v) begin
        $display("px mode=%0d (%0d,%0d) col=%0d", m_mode, x, y, col);
        p++;
      end
      cyc++;
    end
    read_rast_pixel_rdy = 1'b0;
    check("xfers", p, H * V);
    m_fc = (m_fc + 1) % 256;
    check("end_done", rast_done, 1);
    check("end_rdy", rast_pixel_rdy, 0);
    check("end_fc", frame_count, m_fc);
  endtask

  initial begin
    rst = 1'b1; dont_change = 1'b0; mode_sel = 2'd0; mode_auto = 1'b0;
    next_frame_switch = 1'b0; read_rast_pixel_rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check_all_zero("idle");

    run_frame(2'd1, 1'b0, 1'b0, 0, -1, -1);   // bars, full rate
    run_frame(2'd2, 1'b0, 1'b0, 1, -1, -1);   // checker, toggled ready
    run_frame(2'd3, 1'b0, 1'b0, 2, -1, -1);   // gradient
    run_frame(2'd0, 1'b0, 1'b0, 2, -1, -1);   // solid
    repeat (4) run_frame(2'($urandom), 1'b1, 1'b0, 2, -1, -1);
    repeat (3) run_frame(2'($urandom), 1'b1, 1'b1, 0, -1, -1);
    run_frame(2'd1, 1'b0, 1'b0, 0, 10, -1);   // stray swap pulse mid-frame
    run_frame(2'd2, 1'b0, 1'b0, 0, -1, 20);   // reset mid-frame

    repeat (5) begin
      @(negedge clk);
      check("post_rst_done", rast_done, 0);
      check("post_rst_fc", frame_count, 0);
    end
    run_frame(2'd2, 1'b0, 1'b0, 2, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
